// File: rtl/motor_guard.sv
// motor_guard: per-channel H-bridge PWM gating with overcurrent trip, hold-off auto-retry and lockout.
// Define MOTOR_GUARD_DEADTIME_EN to add the direction-reversal dead-time interlock.
`timescale 1ns/1ps

module motor_guard #(
    parameter int CHANNELS        = 2,
    parameter int HOLDOFF_CYCLES  = 1000,
    parameter int CNT_W           = 16,
    parameter int MAX_RETRY       = 3,
    parameter int DEADTIME_CYCLES = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] PWM_IN,
    input  logic [CHANNELS-1:0] DIR,
    input  logic [CHANNELS-1:0] OVER,
    input  logic [CHANNELS-1:0] UNDER,
    input  logic                CLEAR,
    output logic [CHANNELS-1:0] Forward,
    output logic [CHANNELS-1:0] Backward,
    output logic [CHANNELS-1:0] Tripped,
    output logic [CHANNELS-1:0] Locked
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TRIP    = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRY);

    // Parameter sanity checks, evaluated at elaboration only.
    generate
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("motor_guard: CHANNELS must be in 1..8");
        end
        if (HOLDOFF_CYCLES < 2) begin : g_bad_holdoff
            $error("motor_guard: HOLDOFF_CYCLES must be at least 2");
        end
        if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
            $error("motor_guard: MAX_RETRY must be in 1..7");
        end
        if (DEADTIME_CYCLES < 1) begin : g_bad_deadtime
            $error("motor_guard: DEADTIME_CYCLES must be at least 1");
        end
        if ((64'd1 << CNT_W) <= 64'(HOLDOFF_CYCLES) ||
            (64'd1 << CNT_W) <= 64'(DEADTIME_CYCLES)) begin : g_bad_cnt_w
            $error("motor_guard: CNT_W too narrow for HOLDOFF_CYCLES or DEADTIME_CYCLES");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [2:0]       rc_reg, rc_next, rc_eff;
            logic             en_reg, tripped_reg, locked_reg;
            logic             dir_eff, blank;
            logic             fwd_bit, bwd_bit;

            // State register; the status flags are registered from the next state
            // so Tripped/Locked/en are clean flop outputs aligned with the state.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state_reg   <= ST_RUN;
                    cnt_reg     <= '0;
                    rc_reg      <= '0;
                    en_reg      <= 1'b1;
                    tripped_reg <= 1'b0;
                    locked_reg  <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    rc_reg      <= rc_next;
                    en_reg      <= (state_next == ST_RUN);
                    tripped_reg <= (state_next != ST_RUN);
                    locked_reg  <= (state_next == ST_LOCKOUT);
                end
            end

            // Next-state logic. OVER wins over every other condition in every state.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                rc_next    = rc_reg;
                // An expired decay window means this trip starts a fresh count.
                rc_eff     = (cnt_reg == '0) ? 3'd0 : rc_reg;
                case (state_reg)
                    ST_RUN: begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end else begin
                            rc_next = 3'd0;
                        end
                        if (OVER[gi]) begin
                            rc_next = rc_eff + 3'd1;
                            if (rc_eff + 3'd1 < RETRY_LIMIT) begin
                                state_next = ST_TRIP;
                            end else begin
                                state_next = ST_LOCKOUT;
                            end
                        end
                    end
                    ST_TRIP: begin
                        if (!OVER[gi] && UNDER[gi]) begin
                            state_next = ST_HOLDOFF;
                            cnt_next   = HOLD_LOAD;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (OVER[gi]) begin
                            state_next = ST_TRIP;
                        end else if (cnt_reg == '0) begin
                            if (UNDER[gi]) begin
                                state_next = ST_RUN;
                                cnt_next   = HOLD_LOAD;
                            end else begin
                                state_next = ST_TRIP;
                            end
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (CLEAR && UNDER[gi] && !OVER[gi]) begin
                            state_next = ST_RUN;
                            rc_next    = 3'd0;
                            cnt_next   = HOLD_LOAD;
                        end
                    end
                    default: begin
                        state_next = ST_RUN;
                    end
                endcase
            end

`ifdef MOTOR_GUARD_DEADTIME_EN
            localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEADTIME_CYCLES - 1);

            logic             dir_eff_reg, dir_eff_next;
            logic             dir_tgt_reg, dir_tgt_next;
            logic             blank_reg, blank_next;
            logic [CNT_W-1:0] bcnt_reg, bcnt_next;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    dir_eff_reg <= 1'b0;
                    dir_tgt_reg <= 1'b0;
                    blank_reg   <= 1'b0;
                    bcnt_reg    <= '0;
                end else begin
                    dir_eff_reg <= dir_eff_next;
                    dir_tgt_reg <= dir_tgt_next;
                    blank_reg   <= blank_next;
                    bcnt_reg    <= bcnt_next;
                end
            end

            // Blanking runs toward dir_tgt; any further DIR change restarts the count.
            always_comb begin
                dir_eff_next = dir_eff_reg;
                dir_tgt_next = dir_tgt_reg;
                blank_next   = blank_reg;
                bcnt_next    = bcnt_reg;
                if (blank_reg) begin
                    if (DIR[gi] != dir_tgt_reg) begin
                        dir_tgt_next = DIR[gi];
                        bcnt_next    = DT_LOAD;
                    end else if (bcnt_reg == '0) begin
                        blank_next   = 1'b0;
                        dir_eff_next = dir_tgt_reg;
                    end else begin
                        bcnt_next = bcnt_reg - CNT_ONE;
                    end
                end else if (DIR[gi] != dir_eff_reg) begin
                    blank_next   = 1'b1;
                    dir_tgt_next = DIR[gi];
                    bcnt_next    = DT_LOAD;
                end
            end

            assign dir_eff = dir_eff_reg;
            assign blank   = blank_reg;
`else
            assign dir_eff = DIR[gi];
            assign blank   = 1'b0;
`endif

            // Output gating: PWM passes straight through, so edges see no latency.
            always_comb begin
                fwd_bit = PWM_IN[gi] & en_reg & ~blank & ~dir_eff;
                bwd_bit = PWM_IN[gi] & en_reg & ~blank &  dir_eff;
            end

            assign Forward[gi]  = fwd_bit;
            assign Backward[gi] = bwd_bit;
            assign Tripped[gi]  = tripped_reg;
            assign Locked[gi]   = locked_reg;
        end
    endgenerate

endmodule

// File: tb/tb_motor_guard.sv
// tb_motor_guard: directed and randomized checks of motor_guard against a timestamp-based
// behavioural model of trip, hold-off, decay window, lockout and reversal blanking.
`timescale 1ns/1ps

module tb_motor_guard;

    localparam int CH = 2;
    localparam int HO = 4;
    localparam int CW = 8;
    localparam int MR = 3;
    localparam int DT = 8;
`ifdef MOTOR_GUARD_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CLEAR;
    logic [CH-1:0] PWM_IN, DIR, OVER, UNDER;
    logic [CH-1:0] Forward, Backward, Tripped, Locked;

    always #5 CLK = ~CLK;

    motor_guard #(
        .CHANNELS(CH), .HOLDOFF_CYCLES(HO), .CNT_W(CW),
        .MAX_RETRY(MR), .DEADTIME_CYCLES(DT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PWM_IN(PWM_IN), .DIR(DIR),
        .OVER(OVER), .UNDER(UNDER), .CLEAR(CLEAR),
        .Forward(Forward), .Backward(Backward), .Tripped(Tripped), .Locked(Locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge counter plus per-channel flags and timestamps.
    longint t = 0;
    bit     m_off[CH];
    bit     m_lock[CH];
    bit     m_hold[CH];
    longint run_since[CH];
    longint hold_start[CH];
    int     trips[CH];
    bit     m_deff[CH];
    bit     m_blank[CH];
    bit     m_tgt[CH];
    longint blank_end[CH];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_off[c]      = 1'b0;
            m_lock[c]     = 1'b0;
            m_hold[c]     = 1'b0;
            run_since[c]  = t - 1000;
            hold_start[c] = 0;
            trips[c]      = 0;
            m_deff[c]     = 1'b0;
            m_blank[c]    = 1'b0;
            m_tgt[c]      = 1'b0;
            blank_end[c]  = 0;
        end
    endtask

    task automatic model_edge();
        t++;
        for (int c = 0; c < CH; c++) begin
            if (!m_off[c]) begin
                if (OVER[c]) begin
                    if (t - run_since[c] >= HO) trips[c] = 0;
                    trips[c]++;
                    m_off[c]  = 1'b1;
                    m_hold[c] = 1'b0;
                    m_lock[c] = (trips[c] >= MR);
                end
            end else if (m_lock[c]) begin
                if (CLEAR && UNDER[c] && !OVER[c]) begin
                    m_off[c]     = 1'b0;
                    m_lock[c]    = 1'b0;
                    trips[c]     = 0;
                    run_since[c] = t;
                end
            end else if (!m_hold[c]) begin
                if (UNDER[c] && !OVER[c]) begin
                    m_hold[c]     = 1'b1;
                    hold_start[c] = t;
                end
            end else begin
                if (OVER[c]) begin
                    m_hold[c] = 1'b0;
                end else if (t - hold_start[c] >= HO) begin
                    m_hold[c] = 1'b0;
                    if (UNDER[c]) begin
                        m_off[c]     = 1'b0;
                        run_since[c] = t;
                    end
                end
            end
            if (DT_EN) begin
                if (m_blank[c]) begin
                    if (DIR[c] != m_tgt[c]) begin
                        m_tgt[c]     = DIR[c];
                        blank_end[c] = t + DT;
                    end else if (t >= blank_end[c]) begin
                        m_blank[c] = 1'b0;
                        m_deff[c]  = m_tgt[c];
                    end
                end else if (DIR[c] != m_deff[c]) begin
                    m_blank[c]   = 1'b1;
                    m_tgt[c]     = DIR[c];
                    blank_end[c] = t + DT;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0] ef, eb, et, el;
        logic d;
        for (int c = 0; c < CH; c++) begin
            d     = DT_EN ? m_deff[c] : DIR[c];
            ef[c] = PWM_IN[c] & ~m_off[c] & ~m_blank[c] & ~d;
            eb[c] = PWM_IN[c] & ~m_off[c] & ~m_blank[c] &  d;
            et[c] = m_off[c];
            el[c] = m_lock[c];
        end
        chk({tag, "_fwd"},     8'(Forward),  8'(ef));
        chk({tag, "_bwd"},     8'(Backward), 8'(eb));
        chk({tag, "_tripped"}, 8'(Tripped),  8'(et));
        chk({tag, "_locked"},  8'(Locked),   8'(el));
        chk({tag, "_overlap"}, 8'(Forward & Backward), 8'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic pulse_over0();
        OVER[0] = 1'b1;
        tick("over");
        OVER[0] = 1'b0;
    endtask

    initial begin
        RST_N  = 1'b0;
        CLEAR  = 1'b0;
        PWM_IN = '0;
        DIR    = '0;
        OVER   = '0;
        UNDER  = '1;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_tripped", 8'(Tripped), 8'd0);
        chk("rst_locked",  8'(Locked),  8'd0);
        PWM_IN = 2'b11;
        #1;
        chk("rst_fwd", 8'(Forward), 8'h3);
        @(negedge CLK);
        RST_N = 1'b1;

        // Trip and recover with exactly HO hold-off cycles.
        UNDER = 2'b10;
        OVER  = 2'b01;
        tick("t1");
        chk("t1_fwd0_off", 8'(Forward[0]), 8'd0);
        chk("t1_trip0",    8'(Tripped[0]), 8'd1);
        chk("t1_fwd1_on",  8'(Forward[1]), 8'd1);
        OVER = 2'b00;
        tick("t1");
        UNDER = 2'b11;
        tick("t1");
        for (int k = 1; k <= HO; k++) begin
            tick("t1_hold");
            chk("t1_fwd0_hold", 8'(Forward[0]), (k < HO) ? 8'd0 : 8'd1);
            chk("t1_fwd1_hold", 8'(Forward[1]), 8'd1);
        end

        // Re-trip on the second hold-off cycle; hold-off restarts in full, rc unchanged.
        repeat (HO + 2) tick("idle");
        pulse_over0();
        tick("t2");
        tick("t2");
        OVER[0] = 1'b1;
        tick("t2");
        chk("t2_retrip", 8'(Tripped[0]), 8'd1);
        OVER[0] = 1'b0;
        tick("t2");
        for (int k = 1; k <= HO; k++) begin
            tick("t2_hold");
            chk("t2_fwd0_hold", 8'(Forward[0]), (k < HO) ? 8'd0 : 8'd1);
        end
        pulse_over0();
        chk("t2_rc_kept", 8'(Locked[0]), 8'd0);

        // Third trip within the window locks out; CLEAR needs UNDER and no OVER.
        repeat (HO + 1) tick("t3");
        pulse_over0();
        chk("t3_locked", 8'(Locked[0]), 8'd1);
        UNDER = 2'b10;
        CLEAR = 1'b1;
        tick("t3");
        CLEAR = 1'b0;
        chk("t3_clear_ign", 8'(Locked[0]), 8'd1);
        UNDER = 2'b11;
        OVER  = 2'b01;
        CLEAR = 1'b1;
        tick("t3");
        OVER  = 2'b00;
        CLEAR = 1'b0;
        chk("t3_clear_over", 8'(Locked[0]), 8'd1);
        CLEAR = 1'b1;
        tick("t3");
        CLEAR = 1'b0;
        chk("t3_released", 8'(Locked[0]), 8'd0);
        chk("t3_fwd0_back", 8'(Forward[0]), 8'd1);

        // Trips separated by a full clean decay window never lock out.
        for (int n = 0; n < 3; n++) begin
            pulse_over0();
            chk("t4_no_lock", 8'(Locked[0]), 8'd0);
            repeat (HO + 1) tick("t4");
            repeat (HO + 2) tick("t4");
        end

        // Reset in the middle of a lockout.
        pulse_over0();
        repeat (HO + 1) tick("t5");
        pulse_over0();
        repeat (HO + 1) tick("t5");
        pulse_over0();
        chk("t5_locked", 8'(Locked[0]), 8'd1);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_locked",  8'(Locked),  8'd0);
        chk("t5_rst_tripped", 8'(Tripped), 8'd0);
        chk("t5_rst_fwd",     8'(Forward), 8'h3);
        @(negedge CLK);
        RST_N = 1'b1;
        tick("t5");
        chk("t5_fwd0_run", 8'(Forward[0]), 8'd1);

        // Direction reversal at PWM high.
        DIR[0] = 1'b1;
        #1;
`ifdef MOTOR_GUARD_DEADTIME_EN
        chk("t6_bwd_pre", 8'(Backward[0]), 8'd0);
        chk("t6_fwd_pre", 8'(Forward[0]),  8'd1);
        for (int k = 1; k <= DT; k++) begin
            tick("t6");
            chk("t6_fwd_blank", 8'(Forward[0]), 8'd0);
            chk("t6_bwd_blank", 8'(Backward[0]), (k < DT) ? 8'd0 : 8'd1);
        end
`else
        chk("t6_bwd_now", 8'(Backward[0]), 8'd1);
        chk("t6_fwd_now", 8'(Forward[0]),  8'd0);
        tick("t6");
        chk("t6_bwd_held", 8'(Backward[0]), 8'd1);
`endif

        // Randomized traffic against the model, including mid-cycle combinational checks.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                OVER[c]  = ($urandom_range(99) < 4);
                UNDER[c] = ($urandom_range(99) < 80);
                if ($urandom_range(99) < 3) DIR[c] = ~DIR[c];
            end
            PWM_IN = CH'($urandom);
            CLEAR  = ($urandom_range(99) < 6);
            #1;
            check_all("rnd_comb");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
